ps2_command_sequencer: RTL and testbench
========================================

# ps2_command_sequencer

Host-to-keyboard command sequencer for the PS/2 keyboard path. It accepts LED-update and keyboard-reset requests and arbitrates between them, with reset taking priority. It then drives a byte transmitter through each command and its argument bytes, and collects the device's ACK, RESEND and BAT responses from the receive byte stream. It sits beside the scancode converter and asserts `rx_consume` so that response bytes it handles never reach the keycode/IRQ logic.

## Interface
- `ack_timeout`, 16'd20000: clock cycles allowed between `tx_done` and the response byte.
- `bat_timeout`, 24'd5000000: clock cycles allowed between the ACK of FF and the BAT byte.
- `max_retries`, 2'd3: number of retransmits allowed per byte.
- `clock` in 1: system clock; every flop is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `led_request` in 1: one-cycle pulse; requests an LED update.
- `led_state` in 3: sampled when `led_request` is high. Bit 0 = Scroll, bit 1 = Num, bit 2 = Caps.
- `reset_request` in 1: one-cycle pulse; requests a keyboard reset (command FF).
- `tx_valid` out 1: a byte is offered to the transmitter.
- `tx_byte` out 8: the byte being offered.
- `tx_ready` in 1: transmitter accepts the byte; the transfer happens in a cycle where `tx_valid` and `tx_ready` are both high.
- `tx_done` in 1: pulse; the byte has been clocked out and the device acknowledged the line.
- `tx_error` in 1: pulse; the line-level transmit failed.
- `rx_valid` in 1: pulse; `rx_byte` holds a received byte.
- `rx_byte` in 8: received byte.
- `rx_consume` out 1: combinational. High in the same cycle as `rx_valid` when the sequencer absorbs that byte.
- `busy` out 1: high whenever the state is not IDLE.
- `led_applied` out 3: last LED value the device acknowledged.
- `cmd_error` out 1: one-cycle pulse; a sequence was aborted.
- `bat_ok` out 1: one-cycle pulse; the device returned AA after a reset.

## Operation
- Pending requests:
  - `reset_request` sets `pend_rst`.
  - `led_request` sets `pend_led` and loads `led_shadow` from `led_state`. If several requests arrive, the latest value wins, including one arriving mid-sequence.
- Arbitration, evaluated in IDLE only: `pend_rst` is served before `pend_led`. The flag being served is cleared when its sequence starts.
- Reset sequence: send FF, wait for ACK in WAIT_ACK, then go to WAIT_BAT.
- LED sequence: send ED, wait for ACK, then send `led_shadow` (zero-extended to 8 bits), wait for ACK.
  - The data byte is captured into `cur_arg` at the start of the sequence.
  - On the final ACK, `led_applied` is loaded from `cur_arg[2:0]`.
- States and transitions:
  - IDLE → SEND on a pending request.
  - SEND (`tx_valid`=1) → WAIT_TX when the handshake completes.
  - WAIT_TX → WAIT_ACK on `tx_done`; the timer is loaded with `ack_timeout`.
  - WAIT_TX → retry path on `tx_error`.
  - WAIT_ACK, on `rx_valid`:
    - FA: advance to the next byte (SEND), to WAIT_BAT, or to IDLE.
    - FE: go to the retry path.
    - Any other byte: ignored; `rx_consume`=0, so the byte passes through to the keycode path.
  - WAIT_BAT, on `rx_valid`:
    - AA: `bat_ok` pulse, then IDLE.
    - FC: `cmd_error` pulse, then IDLE.
    - Any other byte: ignored.
  - `rx_consume`=1 exactly for FA/FE in WAIT_ACK and AA/FC in WAIT_BAT.
- Retry path: if `retry_cnt` < `max_retries`, increment it and return to SEND with the same byte. Otherwise pulse `cmd_error` and go to IDLE.
  - `retry_cnt` is cleared whenever a new byte is loaded.
- Timer expiry (reaches 0) in WAIT_ACK or WAIT_BAT: `cmd_error` pulse, then IDLE. The aborted request is not re-queued.
- Reset values:
  - `tx_valid`=0, `tx_byte`=00, `busy`=0, `led_applied`=000, `cmd_error`=0, `bat_ok`=0.
  - Pending flags, `led_shadow` and `retry_cnt` are cleared; the timer is 0; the state is IDLE.
- `reset` asserted mid-sequence returns to IDLE immediately and discards all pending requests.

## Timing
- From a request pulse in IDLE to `tx_valid`=1: 2 cycles (latch, then arbitrate).
- `tx_valid` and `tx_byte` stay stable until `tx_ready`. `tx_valid` drops in the cycle after the handshake.
- From ACK `rx_valid` to the next `tx_valid`: 1 cycle.
- `led_applied`, `bat_ok` and `cmd_error` update or pulse in the cycle after the deciding `rx_valid`, `tx_error` or timeout.
- The timer decrements once per cycle while in a wait state. Expiry is checked at 0.
- If `rx_valid` with FA arrives in the same cycle the timer reaches 0, the FA wins.
- If `tx_done` and `tx_error` arrive in the same cycle, `tx_error` wins.
- If `led_request` and `reset_request` arrive in the same cycle, both are latched and the reset is served first.

## Configuration
- Macro: `PS2_CMD_RESEND_RETRY_EN`.
- Defined: FE and `tx_error` trigger retransmission up to `max_retries` times, as described above.
- Undefined: FE and `tx_error` immediately pulse `cmd_error` and return the state to IDLE. The retry counter logic is not built. FE is still consumed (`rx_consume`=1).

## Test plan
- LED update:
  - Stimulus: `led_request` with `led_state`=3'b101; the transmitter accepts immediately; FA follows each `tx_done`.
  - Response: `tx_byte` ED, then 05; `led_applied`=101; `rx_consume` high on both FA bytes; `busy` drops.
- Reset sequence:
  - Stimulus: `reset_request`, FA, then AA.
  - Response: `tx_byte` FF; `bat_ok` pulses once; no `cmd_error`.
  - Repeat with FC instead of AA: `cmd_error` pulses once.
- Resend handling (macro defined):
  - Stimulus: reply FE to ED three times, then FA, FA.
  - Response: ED is sent 4 times and the sequence completes.
  - Stimulus: reply FE four times.
  - Response: `cmd_error` pulses and the state returns to IDLE.
  - Macro undefined, first FE: `cmd_error` pulses.
- Priority and interleave:
  - Stimulus: `led_request` and `reset_request` in the same cycle; during the FF wait, inject scancode 1C.
  - Response: FF is sent first; 1C gets `rx_consume`=0; the LED sequence runs after `bat_ok`.
- Timeout and reset:
  - Stimulus: no reply after `tx_done`.
  - Response: `cmd_error` pulses exactly `ack_timeout`+1 cycles after `tx_done`.
  - Stimulus: assert `reset` during WAIT_ACK.
  - Response: all outputs return to their reset values and the pending LED request is dropped.

Source files
------------

// File: rtl/ps2_command_sequencer.sv
// PS/2 host-to-keyboard command sequencer: arbitrates LED-update and reset
// requests, drives the byte transmitter and absorbs ACK/RESEND/BAT replies.
// Optional feature macro: PS2_CMD_RESEND_RETRY_EN (retransmit on FE / tx_error).
module ps2_command_sequencer #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd20000,
    parameter logic [23:0] BAT_TIMEOUT = 24'd5000000
`ifdef PS2_CMD_RESEND_RETRY_EN
    ,
    parameter logic [1:0]  MAX_RETRIES = 2'd3
`endif
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_led_request,
    input  logic [2:0] i_led_state,
    input  logic       i_reset_request,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_ready,
    input  logic       i_tx_done,
    input  logic       i_tx_error,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_rx_consume,
    output logic       o_busy,
    output logic [2:0] o_led_applied,
    output logic       o_cmd_error,
    output logic       o_bat_ok
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LED_W   = 3;
    localparam int unsigned TIMER_W = 24;

    localparam logic [BYTE_W-1:0] CMD_RESET    = 8'hFF;
    localparam logic [BYTE_W-1:0] CMD_LEDS     = 8'hED;
    localparam logic [BYTE_W-1:0] RSP_ACK      = 8'hFA;
    localparam logic [BYTE_W-1:0] RSP_RESEND   = 8'hFE;
    localparam logic [BYTE_W-1:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [BYTE_W-1:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic                r_pend_rst,    w_pend_rst_nxt;
    logic                r_pend_led,    w_pend_led_nxt;
    logic [LED_W-1:0]    r_led_shadow,  w_led_shadow_nxt;
    logic [BYTE_W-1:0]   r_cur_arg,     w_cur_arg_nxt;
    logic                r_is_rst,      w_is_rst_nxt;
    logic                r_arg_phase,   w_arg_phase_nxt;
    logic [TIMER_W-1:0]  r_timer,       w_timer_nxt;
    logic                r_tx_valid,    w_tx_valid_nxt;
    logic [BYTE_W-1:0]   r_tx_byte,     w_tx_byte_nxt;
    logic                r_busy,        w_busy_nxt;
    logic [LED_W-1:0]    r_led_applied, w_led_applied_nxt;
    logic                r_cmd_error,   w_cmd_error_nxt;
    logic                r_bat_ok,      w_bat_ok_nxt;
    logic                w_retry_req;
`ifdef PS2_CMD_RESEND_RETRY_EN
    logic [1:0]          r_retry_cnt,   w_retry_cnt_nxt;
`endif

    // Response bytes absorbed by the sequencer never reach the keycode path
    assign o_rx_consume = i_rx_valid &&
        (((r_state == S_WAIT_ACK) && ((i_rx_byte == RSP_ACK)    || (i_rx_byte == RSP_RESEND))) ||
         ((r_state == S_WAIT_BAT) && ((i_rx_byte == RSP_BAT_OK) || (i_rx_byte == RSP_BAT_FAIL))));

    // Next-state, datapath and output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_pend_rst_nxt    = r_pend_rst;
        w_pend_led_nxt    = r_pend_led;
        w_led_shadow_nxt  = r_led_shadow;
        w_cur_arg_nxt     = r_cur_arg;
        w_is_rst_nxt      = r_is_rst;
        w_arg_phase_nxt   = r_arg_phase;
        w_timer_nxt       = r_timer;
        w_tx_byte_nxt     = r_tx_byte;
        w_led_applied_nxt = r_led_applied;
        w_cmd_error_nxt   = 1'b0;
        w_bat_ok_nxt      = 1'b0;
        w_retry_req       = 1'b0;
`ifdef PS2_CMD_RESEND_RETRY_EN
        w_retry_cnt_nxt   = r_retry_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (r_pend_rst) begin
                    w_pend_rst_nxt  = 1'b0;
                    w_is_rst_nxt    = 1'b1;
                    w_arg_phase_nxt = 1'b0;
                    w_tx_byte_nxt   = CMD_RESET;
                    w_state_nxt     = S_SEND;
`ifdef PS2_CMD_RESEND_RETRY_EN
                    w_retry_cnt_nxt = 2'd0;
`endif
                end else if (r_pend_led) begin
                    w_pend_led_nxt  = 1'b0;
                    w_is_rst_nxt    = 1'b0;
                    w_arg_phase_nxt = 1'b0;
                    w_cur_arg_nxt   = BYTE_W'(r_led_shadow);
                    w_tx_byte_nxt   = CMD_LEDS;
                    w_state_nxt     = S_SEND;
`ifdef PS2_CMD_RESEND_RETRY_EN
                    w_retry_cnt_nxt = 2'd0;
`endif
                end
            end
            S_SEND: begin
                if (i_tx_ready) w_state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_error) begin
                    w_retry_req = 1'b1;
                end else if (i_tx_done) begin
                    w_timer_nxt = TIMER_W'(ACK_TIMEOUT);
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_rx_valid && (i_rx_byte == RSP_ACK)) begin
                    if (r_is_rst) begin
                        w_timer_nxt = BAT_TIMEOUT;
                        w_state_nxt = S_WAIT_BAT;
                    end else if (!r_arg_phase) begin
                        w_arg_phase_nxt = 1'b1;
                        w_tx_byte_nxt   = r_cur_arg;
                        w_state_nxt     = S_SEND;
`ifdef PS2_CMD_RESEND_RETRY_EN
                        w_retry_cnt_nxt = 2'd0;
`endif
                    end else begin
                        w_led_applied_nxt = r_cur_arg[LED_W-1:0];
                        w_state_nxt       = S_IDLE;
                    end
                end else if (i_rx_valid && (i_rx_byte == RSP_RESEND)) begin
                    w_retry_req = 1'b1;
                end else if (r_timer == '0) begin
                    w_cmd_error_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            S_WAIT_BAT: begin
                if (i_rx_valid && (i_rx_byte == RSP_BAT_OK)) begin
                    w_bat_ok_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (i_rx_valid && (i_rx_byte == RSP_BAT_FAIL)) begin
                    w_cmd_error_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (r_timer == '0) begin
                    w_cmd_error_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Retransmit the same byte or abort the sequence
        if (w_retry_req) begin
`ifdef PS2_CMD_RESEND_RETRY_EN
            if (r_retry_cnt < MAX_RETRIES) begin
                w_retry_cnt_nxt = r_retry_cnt + 2'd1;
                w_state_nxt     = S_SEND;
            end else begin
                w_cmd_error_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
`else
            w_cmd_error_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
`endif
        end

        // New requests are latched after arbitration so they are never lost
        if (i_reset_request) w_pend_rst_nxt = 1'b1;
        if (i_led_request) begin
            w_pend_led_nxt   = 1'b1;
            w_led_shadow_nxt = i_led_state;
        end

        w_tx_valid_nxt = (w_state_nxt == S_SEND);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pend_rst    <= 1'b0;
            r_pend_led    <= 1'b0;
            r_led_shadow  <= '0;
            r_cur_arg     <= '0;
            r_is_rst      <= 1'b0;
            r_arg_phase   <= 1'b0;
            r_timer       <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_byte     <= '0;
            r_busy        <= 1'b0;
            r_led_applied <= '0;
            r_cmd_error   <= 1'b0;
            r_bat_ok      <= 1'b0;
`ifdef PS2_CMD_RESEND_RETRY_EN
            r_retry_cnt   <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pend_rst    <= w_pend_rst_nxt;
            r_pend_led    <= w_pend_led_nxt;
            r_led_shadow  <= w_led_shadow_nxt;
            r_cur_arg     <= w_cur_arg_nxt;
            r_is_rst      <= w_is_rst_nxt;
            r_arg_phase   <= w_arg_phase_nxt;
            r_timer       <= w_timer_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_busy        <= w_busy_nxt;
            r_led_applied <= w_led_applied_nxt;
            r_cmd_error   <= w_cmd_error_nxt;
            r_bat_ok      <= w_bat_ok_nxt;
`ifdef PS2_CMD_RESEND_RETRY_EN
            r_retry_cnt   <= w_retry_cnt_nxt;
`endif
        end
    end

    assign o_tx_valid    = r_tx_valid;
    assign o_tx_byte     = r_tx_byte;
    assign o_busy        = r_busy;
    assign o_led_applied = r_led_applied;
    assign o_cmd_error   = r_cmd_error;
    assign o_bat_ok      = r_bat_ok;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Scoreboard bench for ps2_command_sequencer: expected transmit bytes are
// queued when a request is issued and compared at each tx handshake.
`timescale 1ns/1ps
module tb_ps2_command_sequencer;

    localparam logic [15:0] ACK_T = 16'd200;
    localparam logic [23:0] BAT_T = 24'd300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       led_req = 1'b0;
    logic [2:0] led_state = 3'd0;
    logic       rst_req = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic       tx_error = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       consume;
    logic       busy;
    logic [2:0] led_applied;
    logic       cmd_error;
    logic       bat_ok;

    int n_vec = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int hs_target = 0;
    int n_bat = 0;
    int n_err = 0;
    int base_b = 0;
    int base_e = 0;
    int k = 0;
    logic [7:0] exp_tx[$];

    ps2_command_sequencer #(
        .ACK_TIMEOUT(ACK_T),
        .BAT_TIMEOUT(BAT_T)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_led_request  (led_req),
        .i_led_state    (led_state),
        .i_reset_request(rst_req),
        .o_tx_valid     (tx_valid),
        .o_tx_byte      (tx_byte),
        .i_tx_ready     (tx_ready),
        .i_tx_done      (tx_done),
        .i_tx_error     (tx_error),
        .i_rx_valid     (rx_valid),
        .i_rx_byte      (rx_byte),
        .o_rx_consume   (consume),
        .o_busy         (busy),
        .o_led_applied  (led_applied),
        .o_cmd_error    (cmd_error),
        .o_bat_ok       (bat_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transmit scoreboard and pulse counters
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
            end
            if (bat_ok)    n_bat++;
            if (cmd_error) n_err++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_led(input logic [2:0] v);
        led_state = v;
        led_req = 1'b1;
        step();
        led_req = 1'b0;
    endtask

    task automatic pulse_rst();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
    endtask

    // Wait for the next handshake, then report line-level completion
    task automatic xmit(input logic done, input logic err);
        int n = 0;
        hs_target++;
        while (hs_cnt < hs_target && n < 100) begin
            step();
            n++;
        end
        check("hs_wait", 32'(hs_cnt >= hs_target), 32'd1);
        step();
        tx_done  = done;
        tx_error = err;
        step();
        tx_done  = 1'b0;
        tx_error = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b, input logic exp_consume);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        check("rx_consume", 32'(consume), 32'(exp_consume));
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
    endtask

    task automatic cycles_to_error(input int bound, output int cnt);
        cnt = 0;
        while (!cmd_error && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid",    32'(tx_valid),    32'd0);
        check("rst_tx_byte",     32'(tx_byte),     32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_led_applied", 32'(led_applied), 32'd0);
        check("rst_cmd_error",   32'(cmd_error),   32'd0);
        check("rst_bat_ok",      32'(bat_ok),      32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // LED update with a stalled transmitter first
        tx_ready = 1'b0;
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h05);
        pulse_led(3'b101);
        check("lat1_tx_valid", 32'(tx_valid), 32'd0);
        step();
        check("lat2_tx_valid", 32'(tx_valid), 32'd1);
        check("lat2_busy",     32'(busy),     32'd1);
        repeat (3) step();
        check("hold_tx_valid", 32'(tx_valid), 32'd1);
        check("hold_tx_byte",  32'(tx_byte),  32'hED);
        tx_ready = 1'b1;
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        check("led_applied_101", 32'(led_applied), 32'd5);
        check("led_busy_drop",   32'(busy),        32'd0);

        // Reset sequence, BAT passes
        base_b = n_bat; base_e = n_err;
        exp_tx.push_back(8'hFF);
        pulse_rst();
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        reply(8'hAA, 1'b1);
        check("bat_ok_pulse", 32'(bat_ok), 32'd1);
        step();
        check("bat_ok_drop", 32'(bat_ok), 32'd0);
        check("bat_busy",    32'(busy),   32'd0);
        check("bat_once",    32'(n_bat - base_b), 32'd1);
        check("bat_no_err",  32'(n_err - base_e), 32'd0);

        // Reset sequence, BAT fails
        base_b = n_bat; base_e = n_err;
        exp_tx.push_back(8'hFF);
        pulse_rst();
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        reply(8'hFC, 1'b1);
        step();
        check("fc_err_once", 32'(n_err - base_e), 32'd1);
        check("fc_no_bat",   32'(n_bat - base_b), 32'd0);

        // Simultaneous requests with a scancode interleaved
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h02);
        led_state = 3'b010;
        led_req = 1'b1;
        rst_req = 1'b1;
        step();
        led_req = 1'b0;
        rst_req = 1'b0;
        xmit(1'b1, 1'b0);
        reply(8'h1C, 1'b0);
        reply(8'hFA, 1'b1);
        reply(8'hAA, 1'b1);
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        check("prio_led_applied", 32'(led_applied), 32'd2);

        // ACK timeout
        exp_tx.push_back(8'hED);
        pulse_led(3'b111);
        xmit(1'b1, 1'b0);
        cycles_to_error(int'(ACK_T) + 20, k);
        check("ack_timeout_cycles", 32'(k), 32'(int'(ACK_T) + 1));
        step();
        check("ack_to_busy", 32'(busy),        32'd0);
        check("ack_to_led",  32'(led_applied), 32'd2);
        repeat (5) step();
        check("ack_to_no_requeue", 32'(hs_cnt), 32'(hs_target));

        // BAT timeout
        exp_tx.push_back(8'hFF);
        pulse_rst();
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        cycles_to_error(int'(BAT_T) + 20, k);
        check("bat_timeout_cycles", 32'(k), 32'(int'(BAT_T) + 1));

        // Reset during WAIT_ACK drops the pending request
        exp_tx.push_back(8'hED);
        pulse_led(3'b011);
        xmit(1'b1, 1'b0);
        pulse_led(3'b110);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_valid",    32'(tx_valid),    32'd0);
        check("mid_rst_tx_byte",     32'(tx_byte),     32'd0);
        check("mid_rst_busy",        32'(busy),        32'd0);
        check("mid_rst_led_applied", 32'(led_applied), 32'd0);
        check("mid_rst_cmd_error",   32'(cmd_error),   32'd0);
        check("mid_rst_bat_ok",      32'(bat_ok),      32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        check("mid_rst_no_replay", 32'(hs_cnt), 32'(hs_target));
        check("mid_rst_idle",      32'(busy),   32'd0);

`ifdef PS2_CMD_RESEND_RETRY_EN
        // Three resends then success
        base_e = n_err;
        repeat (4) exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h04);
        pulse_led(3'b100);
        repeat (3) begin
            xmit(1'b1, 1'b0);
            reply(8'hFE, 1'b1);
        end
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        xmit(1'b1, 1'b0);
        reply(8'hFA, 1'b1);
        check("retry_led_applied", 32'(led_applied), 32'd4);
        check("retry_no_err",      32'(n_err - base_e), 32'd0);

        // Four resends exhaust the budget
        base_e = n_err;
        repeat (4) exp_tx.push_back(8'hED);
        pulse_led(3'b001);
        repeat (4) begin
            xmit(1'b1, 1'b0);
            reply(8'hFE, 1'b1);
        end
        check("retry_exhaust_err", 32'(cmd_error), 32'd1);
        step();
        check("retry_exhaust_idle", 32'(busy),            32'd0);
        check("retry_exhaust_once", 32'(n_err - base_e),  32'd1);
        check("retry_exhaust_led",  32'(led_applied),     32'd4);
`else
        // FE aborts immediately
        exp_tx.push_back(8'hED);
        pulse_led(3'b001);
        xmit(1'b1, 1'b0);
        reply(8'hFE, 1'b1);
        check("fe_abort_err", 32'(cmd_error), 32'd1);
        step();
        check("fe_abort_idle", 32'(busy), 32'd0);

        // tx_error wins over a simultaneous tx_done
        exp_tx.push_back(8'hED);
        pulse_led(3'b001);
        xmit(1'b1, 1'b1);
        check("txerr_abort_err", 32'(cmd_error), 32'd1);
        step();
        check("txerr_abort_idle", 32'(busy),        32'd0);
        check("txerr_abort_led",  32'(led_applied), 32'd0);
`endif

        repeat (3) step();
        check("tx_q_drained", 32'(exp_tx.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
